zap_dual_port_mem_model: RTL and testbench
==========================================

Name: zap_dual_port_mem_model

Overview:
Parametrised, synthesizable unified memory for ZAP core benches and FPGA bring-up. It provides one instruction-fetch port and one data load/store port over a shared byte-addressed array. Miss latency is configurable per port, and address-range and privilege aborts are generated. It replaces a fixed-latency, single-configuration cache model between zap_top's o_pc and o_address buses.

Parameters:
DEPTH_BYTES, 4096, array size in bytes; power of two, minimum 64.
ILAT, 2, instruction miss latency in cycles after an address change; 0 to 15.
DLAT, 3, data stall cycles per access; 0 to 15.
PRIV_LIMIT, 256, byte addresses below this abort in User mode.

Ports:
i_clk  in  1  clock, rising edge.
i_reset_n  in  1  asynchronous, active-low reset.
i_cpsr  in  32  CPSR from core; [4:0]==5'b10000 means User mode.
i_iaddr  in  32  instruction fetch address (o_pc).
o_idata  out  32  fetched word.
o_ihit  out  1  o_idata valid for current i_iaddr.
o_iabort  out  1  instruction abort.
i_daddr  in  32  data address.
i_rd_en  in  1  load request.
i_wr_en  in  1  store request; i_rd_en has priority if both are high.
i_ben  in  4  write byte-lane enables.
i_wdata  in  32  store data.
o_rdata  out  32  load data.
o_stall  out  1  data access not complete; master holds request stable.
o_dabort  out  1  data abort.

Behaviour:
- Clock and reset: single clock i_clk; reset i_reset_n is asynchronous, active-low.
- Reset values: all outputs 0; data FSM in D_IDLE; instruction counter 0; last_iaddr = 32'hFFFF_FFFF.
- Array contents are not reset and persist across reset.
- Addressing: little-endian, word-aligned; addr[1:0] ignored; index = addr[log2(DEPTH_BYTES)-1:2].
- Abort condition:
  - addr >= DEPTH_BYTES, or
  - User mode and addr < PRIV_LIMIT.
  - Abort outputs are combinational and qualified by the request.
- Data abort: o_dabort=1 and o_stall=0 in the request cycle. No array write; o_rdata holds its value; FSM stays in D_IDLE.
- Data FSM states: D_IDLE, D_WAIT, D_DONE.
  - D_IDLE, request with no abort, DLAT>0: o_stall=1 combinationally. Next state D_WAIT; cnt <= DLAT-1.
  - D_IDLE, DLAT=0: treated as D_DONE in the same cycle.
  - D_WAIT: o_stall=1. cnt decrements each cycle; at cnt==0 go to D_DONE.
  - D_DONE: o_stall=0. At the rising edge: write commits per i_ben lanes, or read loads o_rdata. Next state D_IDLE.
- Request dropped while in D_WAIT/D_DONE (protocol violation): FSM returns to D_IDLE, no side effect.
- Load-to-use: o_rdata valid the cycle after the final unstalled cycle.
- Instruction port:
  - i_iaddr != last_iaddr at an edge: last_iaddr <= i_iaddr; icnt <= ILAT; o_ihit <= (ILAT==0).
  - Otherwise icnt decrements to 0; o_ihit <= 1 on the edge where icnt reaches 0.
  - o_idata registered from the array each cycle.
  - Address change during a pending miss restarts the count.
- Instruction abort: o_iabort registered alongside o_ihit. The aborting fetch still asserts o_ihit after latency, with o_idata=0.
- Collision: a data write and an instruction fetch to the same word at the same edge give o_idata the new merged word (write-first).
- Reset mid-access: FSM returns to D_IDLE, pending write discarded, o_stall drops asynchronously.

Optional Feature:
ZAP_MEM_RANDOM_STALL_EN: adds a 16-bit Galois LFSR, seed 16'hACE1 on reset, advanced once per cycle.
- Defined: on entering D_WAIT, cnt <= DLAT-1 + lfsr[1:0], adding 0–3 extra stall cycles. DLAT=0 is then treated as DLAT=1.
- Undefined: LFSR absent; latency is exactly DLAT and deterministic.

Test Plan:
- Reset, DLAT=3: write 32'hDEADBEEF to 0x200 with ben=4'hF -> o_stall high 3 cycles, then low one cycle; readback of 0x200 gives o_rdata=32'hDEADBEEF the next cycle.
- Byte lanes: preload 0x204=32'h11223344; write i_wdata=32'hAABBCCDD with ben=4'b0101 -> read returns 32'h11BB33DD.
- Aborts: i_cpsr[4:0]=5'b10000, load 0x40 -> o_dabort=1, o_stall=0, o_rdata unchanged. Load DEPTH_BYTES -> abort. Supervisor mode (5'b10011) load 0x40 -> no abort.
- Fetch, ILAT=2: i_iaddr 0x0 -> 0x4 -> o_ihit low 2 cycles then high with the word at 0x4. Changing the address mid-miss restarts the 2-cycle count.
- Collision: fetch held at 0x208 with hit, store 32'h12345678 to 0x208 -> o_idata=32'h12345678 the cycle after the write edge.
- Assert i_reset_n=0 during D_WAIT of a store -> o_stall 0 immediately; memory word unchanged after release.

Source files
------------

// File: rtl/zap_dual_port_mem_model_if.sv
// rtl/zap_dual_port_mem_model_if.sv - core-side fetch and load/store bus bundle for zap_dual_port_mem_model
//
// Signals (names follow the core's o_pc / o_address bus view):
//   i_cpsr    32  CPSR from core, [4:0]==5'b10000 is User mode
//   i_iaddr   32  instruction fetch address
//   o_idata   32  fetched word
//   o_ihit    1   o_idata valid for the current i_iaddr
//   o_iabort  1   instruction abort
//   i_daddr   32  data address
//   i_rd_en   1   load request (wins over i_wr_en)
//   i_wr_en   1   store request
//   i_ben     4   store byte-lane enables
//   i_wdata   32  store data
//   o_rdata   32  load data
//   o_stall   1   data access not complete
//   o_dabort  1   data abort
// Modports: master = core side, slave = memory side.
interface zap_dual_port_mem_model_if;
  logic [31:0] i_cpsr;
  logic [31:0] i_iaddr;
  logic [31:0] o_idata;
  logic        o_ihit;
  logic        o_iabort;
  logic [31:0] i_daddr;
  logic        i_rd_en;
  logic        i_wr_en;
  logic [3:0]  i_ben;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_stall;
  logic        o_dabort;

  modport master (
    output i_cpsr, i_iaddr, i_daddr, i_rd_en, i_wr_en, i_ben, i_wdata,
    input  o_idata, o_ihit, o_iabort, o_rdata, o_stall, o_dabort
  );

  modport slave (
    input  i_cpsr, i_iaddr, i_daddr, i_rd_en, i_wr_en, i_ben, i_wdata,
    output o_idata, o_ihit, o_iabort, o_rdata, o_stall, o_dabort
  );
endinterface

// File: rtl/zap_dual_port_mem_model.sv
// rtl/zap_dual_port_mem_model.sv - unified fetch + load/store memory with per-port latency and aborts
//
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        zap_dual_port_mem_model_if.slave (fetch port, data port, CPSR)
// Parameters: DEPTH_BYTES (power of two, >= 64), ILAT (0..15), DLAT (0..15), PRIV_LIMIT.
// Optional feature macro: ZAP_MEM_RANDOM_STALL_EN (LFSR-driven 0-3 extra data stall cycles).
// Array contents are never reset.
module zap_dual_port_mem_model #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned ILAT        = 2,
  parameter int unsigned DLAT        = 3,
  parameter int unsigned PRIV_LIMIT  = 256
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  zap_dual_port_mem_model_if.slave   bus
);

  localparam int unsigned AW    = $clog2(DEPTH_BYTES);
  localparam int unsigned WORDS = DEPTH_BYTES / 4;

`ifdef ZAP_MEM_RANDOM_STALL_EN
  localparam int unsigned DLAT_EFF = (DLAT == 0) ? 1 : DLAT;
`else
  localparam int unsigned DLAT_EFF = DLAT;
`endif

  // cnt holds the number of D_WAIT cycles still to spend; the D_IDLE request
  // cycle is itself the first stall cycle, so a base of DLAT-1 yields DLAT stalls.
  localparam logic [4:0] CNT_BASE = 5'((DLAT_EFF == 0) ? 0 : DLAT_EFF - 1);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_DONE} dstate_t;

  logic [31:0] mem [WORDS];

  function automatic logic addr_abort(input logic [31:0] a, input logic user);
    return (a >= 32'(DEPTH_BYTES)) || (user && (a < 32'(PRIV_LIMIT)));
  endfunction

  logic          user_mode;
  logic          d_req;
  logic          d_bad;
  logic          f_bad;
  logic [AW-3:0] d_idx;
  logic [AW-3:0] f_idx;
  logic          unused_cpsr_hi;

  assign user_mode      = (bus.i_cpsr[4:0] == 5'b10000);
  assign unused_cpsr_hi = &{1'b0, bus.i_cpsr[31:5]};
  assign d_req          = bus.i_rd_en | bus.i_wr_en;
  assign d_bad          = addr_abort(bus.i_daddr, user_mode);
  assign f_bad          = addr_abort(bus.i_iaddr, user_mode);
  assign d_idx          = bus.i_daddr[AW-1:2];
  assign f_idx          = bus.i_iaddr[AW-1:2];

  dstate_t     state;
  logic [4:0]  cnt;
  logic [4:0]  cnt_init;
  logic [31:0] rdata_q;

`ifdef ZAP_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
    end
  end

  assign cnt_init = CNT_BASE + {3'b000, lfsr[1:0]};
`else
  assign cnt_init = CNT_BASE;
`endif

  // Access completes this cycle: D_DONE, or D_IDLE when there is no latency.
  // Gated by reset so nothing commits while reset is held.
  logic d_done;
  logic rd_commit;
  logic wr_commit;
  assign d_done    = i_reset_n && d_req && !d_bad &&
                     ((state == D_DONE) || ((state == D_IDLE) && (DLAT_EFF == 0)));
  assign rd_commit = d_done && bus.i_rd_en;
  assign wr_commit = d_done && !bus.i_rd_en && bus.i_wr_en;

  logic [31:0] d_old;
  logic [31:0] wr_word;
  assign d_old = mem[d_idx];

  always_comb begin
    wr_word = d_old;
    for (int b = 0; b < 4; b++) begin
      if (bus.i_ben[b]) wr_word[8*b +: 8] = bus.i_wdata[8*b +: 8];
    end
  end

  // Stall and abort are combinational; forcing them low under reset makes
  // o_stall drop the moment reset is asserted.
  logic stall_c;
  always_comb begin
    stall_c = 1'b0;
    if (i_reset_n && d_req && !d_bad) begin
      case (state)
        D_IDLE:  stall_c = (DLAT_EFF != 0);
        D_WAIT:  stall_c = 1'b1;
        default: stall_c = 1'b0;
      endcase
    end
  end

  assign bus.o_stall  = stall_c;
  assign bus.o_dabort = i_reset_n && d_req && d_bad && (state == D_IDLE);
  assign bus.o_rdata  = rdata_q;

  always_ff @(posedge i_clk) begin
    if (wr_commit) mem[d_idx] <= wr_word;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= D_IDLE;
      cnt     <= 5'd0;
      rdata_q <= 32'h0;
    end else begin
      if (rd_commit) rdata_q <= d_old;
      case (state)
        D_IDLE: begin
          if (d_req && !d_bad && (DLAT_EFF != 0)) begin
            if (cnt_init == 5'd0) begin
              state <= D_DONE;
            end else begin
              state <= D_WAIT;
              cnt   <= cnt_init;
            end
          end
        end
        D_WAIT: begin
          // A dropped or changed-to-aborting request abandons the access.
          if (!d_req || d_bad) begin
            state <= D_IDLE;
            cnt   <= 5'd0;
          end else if (cnt <= 5'd1) begin
            state <= D_DONE;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

  logic [31:0] last_iaddr;
  logic [3:0]  icnt;
  logic [3:0]  icnt_nxt;
  logic        ihit_q;
  logic        ihit_nxt;
  logic        iabort_q;
  logic [31:0] idata_q;

  always_comb begin
    icnt_nxt = icnt;
    ihit_nxt = ihit_q;
    if (bus.i_iaddr != last_iaddr) begin
      icnt_nxt = 4'(ILAT);
      ihit_nxt = (ILAT == 0);
    end else if (icnt != 4'd0) begin
      icnt_nxt = icnt - 4'd1;
      ihit_nxt = (icnt == 4'd1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_iaddr <= 32'hFFFF_FFFF;
      icnt       <= 4'd0;
      ihit_q     <= 1'b0;
      iabort_q   <= 1'b0;
      idata_q    <= 32'h0;
    end else begin
      last_iaddr <= bus.i_iaddr;
      icnt       <= icnt_nxt;
      ihit_q     <= ihit_nxt;
      iabort_q   <= ihit_nxt && f_bad;
      // Write-first: a store landing on the fetched word this edge is forwarded.
      if (f_bad) begin
        idata_q <= 32'h0;
      end else if (wr_commit && (d_idx == f_idx)) begin
        idata_q <= wr_word;
      end else begin
        idata_q <= mem[f_idx];
      end
    end
  end

  assign bus.o_ihit   = ihit_q;
  assign bus.o_iabort = iabort_q;
  assign bus.o_idata  = idata_q;

endmodule

// File: tb/tb_zap_dual_port_mem_model.sv
// tb/tb_zap_dual_port_mem_model.sv - scoreboard bench for zap_dual_port_mem_model
module tb_zap_dual_port_mem_model;
  localparam int DEPTH = 4096;
  localparam int ILAT  = 2;
  localparam int DLAT  = 3;
  localparam int PRIV  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zap_dual_port_mem_model_if bus();

  zap_dual_port_mem_model #(
    .DEPTH_BYTES(DEPTH), .ILAT(ILAT), .DLAT(DLAT), .PRIV_LIMIT(PRIV)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        abort;
    logic [31:0] data;
  } exp_t;

  exp_t d_q[$];
  exp_t i_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata = 32'h0;
  bit          user_mode = 1'b0;
  int          widx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_abort(input logic [31:0] a, input bit u);
    return (a >= 32'(DEPTH)) || (u && (a < 32'(PRIV)));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] ben);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Data monitor: one cycle after a finishing (unstalled) request cycle,
  // compare the abort seen in that cycle and the now-registered o_rdata.
  bit fin_prev = 1'b0;
  bit ab_prev  = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      fin_prev = 1'b0;
    end else begin
      if (fin_prev) begin
        if (d_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL data_unexpected: completion with empty scoreboard");
        end else begin
          exp_t e;
          e = d_q.pop_front();
          check("dabort", {31'h0, ab_prev}, {31'h0, e.abort});
          check("rdata", bus.o_rdata, e.data);
        end
      end
      fin_prev = (bus.i_rd_en || bus.i_wr_en) && !bus.o_stall;
      ab_prev  = bus.o_dabort;
    end
  end

  // Fetch monitor: every rising o_ihit consumes one expected fetch.
  bit ihit_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ihit_prev = 1'b0;
    end else begin
      if (bus.o_ihit && !ihit_prev && i_q.size() > 0) begin
        exp_t e;
        e = i_q.pop_front();
        check("idata", bus.o_idata, e.data);
        check("iabort", {31'h0, bus.o_iabort}, {31'h0, e.abort});
      end
      ihit_prev = bus.o_ihit;
    end
  end

  task automatic set_mode(input bit u);
    @(posedge clk); #1;
    user_mode  = u;
    bus.i_cpsr = u ? 32'h0000_0010 : 32'h0000_0013;
  endtask

  task automatic data_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] ben, input logic [31:0] wdata);
    exp_t e;
    int   stalls;
    int   widx;
    bit   ab;
    ab   = is_abort(addr, user_mode);
    widx = int'(addr[31:2]);
    if (!ab && rd) ref_rdata = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
    e.abort = ab;
    e.data  = ref_rdata;
    if (!ab && !rd && wr) begin
      ref_mem[widx] = merge(ref_mem.exists(widx) ? ref_mem[widx] : 32'h0, wdata, ben);
    end
    d_q.push_back(e);
    @(posedge clk); #1;
    bus.i_daddr = addr; bus.i_rd_en = rd; bus.i_wr_en = wr;
    bus.i_ben = ben; bus.i_wdata = wdata;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!bus.o_stall) break;
      stalls++;
      if (stalls > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL stall_timeout: addr %h still stalled after %0d cycles", addr, stalls);
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_rd_en = 1'b0; bus.i_wr_en = 1'b0;
    if (ab) begin
      check("abort_stall_cycles", 32'(stalls), 32'd0);
    end else begin
`ifdef ZAP_MEM_RANDOM_STALL_EN
      n_cmp++;
      if (stalls < ((DLAT == 0) ? 1 : DLAT) || stalls > ((DLAT == 0) ? 1 : DLAT) + 3) begin
        n_bad++;
        $display("FAIL stall_cycles: got %0d outside random range", stalls);
      end
`else
      check("stall_cycles", 32'(stalls), 32'(DLAT));
`endif
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input bit use_detour, input logic [31:0] detour);
    exp_t e;
    int   lows;
    if (use_detour) begin
      @(posedge clk); #1;
      bus.i_iaddr = detour;
    end
    @(posedge clk); #1;
    bus.i_iaddr = addr;
    e.abort = is_abort(addr, user_mode);
    e.data  = (e.abort || !ref_mem.exists(int'(addr[31:2]))) ? 32'h0 : ref_mem[int'(addr[31:2])];
    i_q.push_back(e);
    @(posedge clk);
    lows = 0;
    forever begin
      @(negedge clk);
      if (bus.o_ihit) break;
      lows++;
      if (lows > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL fetch_timeout: addr %h no hit after %0d cycles", addr, lows);
        break;
      end
    end
    check("fetch_latency", 32'(lows), 32'(ILAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_cpsr = 32'h0000_0013; bus.i_iaddr = 32'h0;
    bus.i_daddr = 32'h0; bus.i_rd_en = 1'b0; bus.i_wr_en = 1'b0;
    bus.i_ben = 4'h0; bus.i_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_ihit",   {31'h0, bus.o_ihit},   32'h0);
    check("reset_iabort", {31'h0, bus.o_iabort}, 32'h0);
    check("reset_idata",  bus.o_idata,           32'h0);
    check("reset_rdata",  bus.o_rdata,           32'h0);
    check("reset_stall",  {31'h0, bus.o_stall},  32'h0);
    check("reset_dabort", {31'h0, bus.o_dabort}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    data_op(0, 1, 32'h200, 4'hF, 32'hDEADBEEF);
    data_op(1, 0, 32'h200, 4'h0, 32'h0);
    data_op(0, 1, 32'h204, 4'hF, 32'h11223344);
    data_op(0, 1, 32'h204, 4'b0101, 32'hAABBCCDD);
    data_op(1, 0, 32'h204, 4'h0, 32'h0);

    data_op(0, 1, 32'h40, 4'hF, 32'hCAFEF00D);
    set_mode(1);
    data_op(1, 0, 32'h40, 4'h0, 32'h0);
    set_mode(0);
    data_op(1, 0, 32'(DEPTH), 4'h0, 32'h0);
    data_op(1, 0, 32'h40, 4'h0, 32'h0);

    data_op(0, 1, 32'h4, 4'hF, 32'h0BADF00D);
    data_op(0, 1, 32'h8, 4'hF, 32'h88888888);
    data_op(0, 1, 32'hC, 4'hF, 32'hC0C0C0C0);
    fetch(32'h4, 0, 32'h0);
    fetch(32'hC, 1, 32'h8);

    data_op(0, 1, 32'h208, 4'hF, 32'h55AA55AA);
    fetch(32'h208, 0, 32'h0);
    data_op(0, 1, 32'h208, 4'hF, 32'h12345678);
    @(negedge clk);
    check("collision_idata", bus.o_idata, ref_mem[32'h208 >> 2]);

    set_mode(1);
    fetch(32'h10, 0, 32'h0);
    set_mode(0);
    fetch(32'h204, 0, 32'h0);

    for (int i = 0; i < 16; i++) widx_q.push_back(int'(32'h200 >> 2) + (i % 2));
    for (int it = 0; it < 60; it++) begin
      int r;
      int idx;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        data_op(1, 0, 32'(DEPTH) + 32'($urandom_range(0, 1000) * 4), 4'h0, 32'h0);
      end else if (r <= 4) begin
        idx = $urandom_range(64, 1023);
        data_op(0, 1, 32'(idx * 4), ref_mem.exists(idx) ? 4'($urandom) : 4'hF, $urandom);
        widx_q.push_back(idx);
      end else begin
        idx = widx_q[$urandom_range(0, widx_q.size() - 1)];
        data_op(1, (r == 9), 32'(idx * 4), 4'($urandom), $urandom);
      end
      if (it % 8 == 7) begin
        idx = widx_q[$urandom_range(0, widx_q.size() - 1)];
        if (32'(idx * 4) != bus.i_iaddr) fetch(32'(idx * 4), 0, 32'h0);
      end
    end

    data_op(0, 1, 32'h300, 4'hF, 32'h0F0F1234);
    @(posedge clk); #1;
    bus.i_daddr = 32'h300; bus.i_wr_en = 1'b1; bus.i_ben = 4'hF; bus.i_wdata = 32'hFFFF0000;
    @(negedge clk);
    check("pre_reset_stall", {31'h0, bus.o_stall}, 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_stall", {31'h0, bus.o_stall}, 32'h0);
    bus.i_wr_en = 1'b0;
    ref_rdata = 32'h0;
    @(negedge clk);
    check("reset_rdata_mid", bus.o_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    data_op(1, 0, 32'h300, 4'h0, 32'h0);

    repeat (5) @(negedge clk);
    check("data_queue_drained",  32'(d_q.size()), 32'd0);
    check("fetch_queue_drained", 32'(i_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
